imem_loader: RTL and testbench

Byte-stream program loader that writes the processor's 16-bit instruction memory. It replaces the hard-coded program image and is the write-side counterpart of the fetch path. It takes framed bytes from a serial receiver through a valid/ready interface, assembles instruction words and writes them to the memory write port. It holds the processor in reset while loading and releases it only after the checksum verifies.

---
 rtl/imem_loader_if.sv | 29 ++
 rtl/imem_loader.sv | 143 ++++++++++++++
 tb/tb_imem_loader.sv | 374 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader_if
// Brief    : Byte-stream input and instruction-memory write port of the loader.
// Revision : 1.0 - initial release
// ============================================================================
interface imem_loader_if #(
    parameter int ADDR_W = 6
);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;

    // The loader is the stream sink and drives the memory write port.
    modport slave (
        input  in_data, in_valid,
        output in_ready, mem_we, mem_addr, mem_wdata
    );

    // The byte source / memory side.
    modport master (
        output in_data, in_valid,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Brief    : Frames LEN / word bytes / CSUM into 16-bit instruction-memory
//            writes and holds the processor in reset until the load verifies.
// Revision : 1.0 - initial release
// ============================================================================
module imem_loader #(
    parameter int MEM_DEPTH = 64,
    parameter int ADDR_W    = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    imem_loader_if.slave      bus,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err_len,
    output logic              err_csum,
    output logic [ADDR_W:0]   word_count
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LEN  = 3'd1,
        S_HI   = 3'd2,
        S_LO   = 3'd3,
        S_CSUM = 3'd4,
        S_DONE = 3'd5,
        S_ERR  = 3'd6
    } state_t;

    localparam logic [8:0] c_depth = 9'(MEM_DEPTH);

    state_t            r_state;
    logic [7:0]        r_csum;
    logic [7:0]        r_hi;
    logic [ADDR_W:0]   r_len;
    logic [ADDR_W:0]   r_wcount;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [15:0]       r_mem_wdata;
    logic              r_cpu_hold;
    logic              r_done;
    logic              r_err_len;
    logic              r_err_csum;

    logic              w_ready;
    logic              w_xfer;
    logic              w_len_bad;
    logic [ADDR_W:0]   w_wcount_inc;

    // Readiness depends on state only, so in_valid never loops back to in_ready.
    assign w_ready      = (r_state == S_LEN) || (r_state == S_HI) ||
                          (r_state == S_LO)  || (r_state == S_CSUM);
    assign w_xfer       = w_ready && bus.in_valid;
    assign w_len_bad    = (bus.in_data == 8'd0) || ({1'b0, bus.in_data} > c_depth);
    assign w_wcount_inc = r_wcount + (ADDR_W+1)'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_csum      <= 8'd0;
            r_hi        <= 8'd0;
            r_len       <= '0;
            r_wcount    <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= 16'd0;
            r_cpu_hold  <= 1'b0;
            r_done      <= 1'b0;
            r_err_len   <= 1'b0;
            r_err_csum  <= 1'b0;
        end else begin
            r_mem_we <= 1'b0;
            // Count a word once its write strobe has been presented.
            if (r_mem_we) begin
                r_wcount <= w_wcount_inc;
            end
            if (start) begin
                r_state    <= S_LEN;
                r_done     <= 1'b0;
                r_err_len  <= 1'b0;
                r_err_csum <= 1'b0;
                r_wcount   <= '0;
                r_csum     <= 8'd0;
                r_cpu_hold <= 1'b1;
            end else if (w_xfer) begin
                case (r_state)
                    S_LEN: begin
                        if (w_len_bad) begin
                            r_state   <= S_ERR;
                            r_err_len <= 1'b1;
                        end else begin
                            r_len   <= (ADDR_W+1)'(bus.in_data);
                            r_csum  <= bus.in_data;
                            r_state <= S_HI;
                        end
                    end
                    S_HI: begin
                        r_hi    <= bus.in_data;
                        r_csum  <= r_csum ^ bus.in_data;
                        r_state <= S_LO;
                    end
                    S_LO: begin
                        // The previous word's count update has always landed
                        // by now: at least one HI cycle separates LO transfers.
                        r_csum      <= r_csum ^ bus.in_data;
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= r_wcount[ADDR_W-1:0];
                        r_mem_wdata <= {r_hi, bus.in_data};
                        r_state     <= (w_wcount_inc == r_len) ? S_CSUM : S_HI;
                    end
                    S_CSUM: begin
                        if (bus.in_data == r_csum) begin
                            r_state    <= S_DONE;
                            r_done     <= 1'b1;
                            r_cpu_hold <= 1'b0;
                        end else begin
                            r_state    <= S_ERR;
                            r_err_csum <= 1'b1;
                        end
                    end
                    default: r_state <= r_state;
                endcase
            end
        end
    end

    assign bus.in_ready  = w_ready;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign busy          = w_ready;
    assign cpu_hold      = r_cpu_hold;
    assign done          = r_done;
    assign err_len       = r_err_len;
    assign err_csum      = r_err_csum;
    assign word_count    = r_wcount;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_loader
// Brief    : Self-checking bench for imem_loader with a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_imem_loader;
    localparam int MEM_DEPTH = 64;
    localparam int ADDR_W    = 6;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              cpu_hold, busy, done, err_len, err_csum;
    logic [ADDR_W:0]   word_count;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus();

    imem_loader #(.MEM_DEPTH(MEM_DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bus(bus),
        .cpu_hold(cpu_hold), .busy(busy), .done(done),
        .err_len(err_len), .err_csum(err_csum), .word_count(word_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Every observed write, as {addr, data}; only this monitor appends.
    logic [21:0] obs_q[$];
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) obs_q.push_back({bus.mem_addr, bus.mem_wdata});
    end

    logic [7:0]      frame_q[$];
    logic [21:0]     exp_w[$];
    logic [4:0]      exp_flags;   // {done, err_len, err_csum, cpu_hold, busy}
    logic [ADDR_W:0] exp_wc;
    int              base;

    // Frame-level reference: what a whole frame must leave behind.
    task automatic model_frame();
        int n;
        logic [7:0] x;
        exp_w.delete();
        n = int'(frame_q[0]);
        if (n == 0 || n > MEM_DEPTH) begin
            exp_flags = 5'b01010;
            exp_wc    = '0;
            return;
        end
        x = frame_q[0];
        for (int i = 0; i < n; i++) begin
            exp_w.push_back({6'(i), frame_q[1+2*i], frame_q[2+2*i]});
            x = x ^ frame_q[1+2*i] ^ frame_q[2+2*i];
        end
        exp_wc    = 7'(n);
        exp_flags = (frame_q[2*n+1] == x) ? 5'b10000 : 5'b00110;
    endtask

    task automatic build_frame(input int n, input bit corrupt);
        logic [7:0] x;
        frame_q.delete();
        frame_q.push_back(8'(n));
        x = 8'(n);
        for (int i = 0; i < 2*n; i++) begin
            frame_q.push_back(8'($urandom));
            x = x ^ frame_q[$];
        end
        frame_q.push_back(corrupt ? (x ^ 8'($urandom_range(1, 255))) : x);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        bit ok;
        ok = 1'b0;
        if (gaps) begin
            repeat ($urandom_range(0, 3)) begin
                bus.in_valid = 1'b0;
                bus.in_data  = 8'($urandom);
                @(posedge clk); #1;
            end
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL send_timeout: byte %02h never accepted, in_ready=%b want 1", b, bus.in_ready);
        end
    endtask

    task automatic send_frame(input bit gaps);
        foreach (frame_q[i]) send_byte(frame_q[i], gaps);
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h5A;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.in_ready, busy, bus.mem_we, done, err_len, err_csum, cpu_hold} !== 7'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b want 0000000",
                     {bus.in_ready, busy, bus.mem_we, done, err_len, err_csum, cpu_hold});
        end
        checks++;
        if ({bus.mem_addr, bus.mem_wdata, word_count} !== '0) begin
            errors++;
            $display("FAIL reset_bus: addr=%0h data=%0h wc=%0d want 0", bus.mem_addr, bus.mem_wdata, word_count);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.in_ready, busy, cpu_hold} !== 3'b000) begin
            errors++;
            $display("FAIL idle_ready: got %b want 000", {bus.in_ready, busy, cpu_hold});
        end
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_normal();
        frame_q = '{8'h02, 8'h00, 8'h05, 8'h04, 8'h0A, 8'h09};
        exp_w   = '{{6'd0, 16'h0005}, {6'd1, 16'h040A}};
        base = obs_q.size();
        pulse_start();
        send_frame(1'b0);
        checks++;
        if (obs_q.size() - base != 2) begin
            errors++;
            $display("FAIL normal_nwr: got %0d writes want 2", obs_q.size() - base);
        end
        for (int i = 0; i < 2 && base + i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[base+i] !== exp_w[i]) begin
                errors++;
                $display("FAIL normal_wr%0d: got %h want %h", i, obs_q[base+i], exp_w[i]);
            end
        end
        checks++;
        if ({done, err_len, err_csum, cpu_hold, busy, word_count} !== {5'b10000, 7'd2}) begin
            errors++;
            $display("FAIL normal_flags: got %b wc=%0d want 10000 wc=2",
                     {done, err_len, err_csum, cpu_hold, busy}, word_count);
        end
    endtask

    task automatic test_backpressure();
        frame_q = '{8'h02, 8'h00, 8'h05, 8'h04, 8'h0A, 8'h09};
        model_frame();
        base = obs_q.size();
        pulse_start();
        send_frame(1'b1);
        checks++;
        if (obs_q.size() - base != exp_w.size()) begin
            errors++;
            $display("FAIL bp_nwr: got %0d want %0d", obs_q.size() - base, exp_w.size());
        end
        for (int i = 0; i < exp_w.size() && base + i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[base+i] !== exp_w[i]) begin
                errors++;
                $display("FAIL bp_wr%0d: got %h want %h", i, obs_q[base+i], exp_w[i]);
            end
        end
        // Offer bytes while DONE: none may be taken.
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hEE;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({bus.in_ready, done, cpu_hold, word_count} !== {3'b010, exp_wc}) begin
                errors++;
                $display("FAIL bp_done_idle: got rdy=%b done=%b hold=%b wc=%0d want 0 1 0 %0d",
                         bus.in_ready, done, cpu_hold, word_count, exp_wc);
            end
        end
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_len_err();
        logic [7:0] lens [2];
        lens = '{8'h00, 8'h41};
        for (int t = 0; t < 2; t++) begin
            frame_q = '{lens[t]};
            model_frame();
            base = obs_q.size();
            pulse_start();
            send_frame(1'b0);
            checks++;
            if ({done, err_len, err_csum, cpu_hold, busy} !== 5'b01010 || obs_q.size() != base) begin
                errors++;
                $display("FAIL len_err_%02h: flags=%b writes=%0d want 01010 writes=0",
                         lens[t], {done, err_len, err_csum, cpu_hold, busy}, obs_q.size() - base);
            end
        end
    endtask

    task automatic test_csum_err();
        frame_q = '{8'h01, 8'h12, 8'h34, 8'h00};
        base = obs_q.size();
        pulse_start();
        send_frame(1'b0);
        checks++;
        if (obs_q.size() - base != 1 || obs_q[base] !== {6'd0, 16'h1234}) begin
            errors++;
            $display("FAIL csum_wr: writes=%0d first=%h want 1 write 001234",
                     obs_q.size() - base, (obs_q.size() > base) ? obs_q[base] : 22'h0);
        end
        checks++;
        if ({done, err_len, err_csum, cpu_hold} !== 4'b0011) begin
            errors++;
            $display("FAIL csum_flags: got %b want 0011", {done, err_len, err_csum, cpu_hold});
        end
    endtask

    task automatic test_abort();
        bit lo_ready;
        base = obs_q.size();
        pulse_start();
        send_byte(8'h02, 1'b0);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        send_byte(8'hCC, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hDD;
        start        = 1'b1;
        @(negedge clk);
        lo_ready = bus.in_ready;
        @(posedge clk); #1;
        start        = 1'b0;
        bus.in_valid = 1'b0;
        frame_q = '{8'h01, 8'h00, 8'h07, 8'h06};
        send_frame(1'b0);
        checks++;
        if (!lo_ready) begin
            errors++;
            $display("FAIL abort_dd_offered: in_ready=%b want 1", lo_ready);
        end
        exp_w = '{{6'd0, 16'hAABB}, {6'd0, 16'h0007}};
        checks++;
        if (obs_q.size() - base != 2) begin
            errors++;
            $display("FAIL abort_nwr: got %0d want 2", obs_q.size() - base);
        end
        for (int i = 0; i < 2 && base + i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[base+i] !== exp_w[i]) begin
                errors++;
                $display("FAIL abort_wr%0d: got %h want %h", i, obs_q[base+i], exp_w[i]);
            end
        end
        checks++;
        if ({done, err_len, err_csum, cpu_hold, word_count} !== {4'b1000, 7'd1}) begin
            errors++;
            $display("FAIL abort_flags: got %b wc=%0d want 1000 wc=1",
                     {done, err_len, err_csum, cpu_hold}, word_count);
        end
    endtask

    task automatic test_async_reset();
        for (int t = 0; t < 2; t++) begin
            base = obs_q.size();
            pulse_start();
            send_byte(8'h02, 1'b0);
            send_byte(8'h11, 1'b0);
            if (t == 1) send_byte(8'h22, 1'b0);   // second pass cuts a pending write
            #2;
            rst_n = 1'b0;
            #1;
            checks++;
            if ({bus.in_ready, busy, bus.mem_we, done, err_len, err_csum, cpu_hold,
                 bus.mem_addr, bus.mem_wdata, word_count} !== '0) begin
                errors++;
                $display("FAIL arst_%0d: rdy=%b we=%b hold=%b addr=%0h data=%h wc=%0d want all 0",
                         t, bus.in_ready, bus.mem_we, cpu_hold, bus.mem_addr, bus.mem_wdata, word_count);
            end
            @(posedge clk); #1;
            rst_n = 1'b1;
            @(negedge clk);
            checks++;
            if (obs_q.size() != base) begin
                errors++;
                $display("FAIL arst_nowrite_%0d: got %0d writes want 0", t, obs_q.size() - base);
            end
            @(posedge clk); #1;
        end
        build_frame(3, 1'b0);
        model_frame();
        base = obs_q.size();
        pulse_start();
        send_frame(1'b0);
        checks++;
        if (obs_q.size() - base != exp_w.size() ||
            {done, err_len, err_csum, cpu_hold, busy} !== exp_flags) begin
            errors++;
            $display("FAIL arst_reload: writes=%0d flags=%b want %0d %b",
                     obs_q.size() - base, {done, err_len, err_csum, cpu_hold, busy}, exp_w.size(), exp_flags);
        end
        for (int i = 0; i < exp_w.size() && base + i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[base+i] !== exp_w[i]) begin
                errors++;
                $display("FAIL arst_reload_wr%0d: got %h want %h", i, obs_q[base+i], exp_w[i]);
            end
        end
    endtask

    task automatic test_random();
        int n;
        for (int f = 0; f < 8; f++) begin
            n = (f == 7) ? MEM_DEPTH : $urandom_range(1, 10);
            build_frame(n, ($urandom_range(0, 2) == 0));
            model_frame();
            base = obs_q.size();
            pulse_start();
            send_frame(1'b1);
            checks++;
            if (obs_q.size() - base != exp_w.size()) begin
                errors++;
                $display("FAIL rnd%0d_nwr: got %0d want %0d", f, obs_q.size() - base, exp_w.size());
            end
            for (int i = 0; i < exp_w.size() && base + i < obs_q.size(); i++) begin
                checks++;
                if (obs_q[base+i] !== exp_w[i]) begin
                    errors++;
                    $display("FAIL rnd%0d_wr%0d: got %h want %h", f, i, obs_q[base+i], exp_w[i]);
                end
            end
            checks++;
            if ({done, err_len, err_csum, cpu_hold, busy} !== exp_flags || word_count !== exp_wc) begin
                errors++;
                $display("FAIL rnd%0d_flags: got %b wc=%0d want %b wc=%0d", f,
                         {done, err_len, err_csum, cpu_hold, busy}, word_count, exp_flags, exp_wc);
            end
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        test_reset();
        test_normal();
        test_backpressure();
        test_len_err();
        test_csum_err();
        test_abort();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
